// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the instruction fetch path.
//   XLEN          - address / instruction width used by buffer entries
//   INSTR_BYTES   - fetch PC increment per word
//   NOP_INSTR     - instruction presented to decode when nothing is valid
//   fetch_entry_t - one buffer slot: fetch PC, returned word, filled flag
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: ring of DEPTH fetch entries shared by three pointers.
//   wr_ptr   - next slot to allocate (PC stored when the request is accepted)
//   fill_ptr - next slot to receive returned data (responses come back in order)
//   rd_ptr   - head slot presented to decode
// Ports:
//   clk, rst_n             clock, async active-low reset
//   flush                  drop every entry and return all pointers to 0
//   alloc_en / alloc_pc    allocate wr_ptr slot with this PC
//   fill_en / fill_data    write instruction into fill_ptr slot, mark filled
//   pop_en                 release head slot
//   head_valid/pc/instr    contents of head slot
module fetch_buf
  import riscv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            alloc_en,
  input  logic [XLEN-1:0] alloc_pc,
  input  logic            fill_en,
  input  logic [XLEN-1:0] fill_data,
  input  logic            pop_en,
  output logic            head_valid,
  output logic [XLEN-1:0] head_pc,
  output logic [XLEN-1:0] head_instr
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] fill_ptr_r;
  logic [PW-1:0] rd_ptr_r;

  // Ring storage and pointer update. The three slots touched in one cycle are
  // always distinct: alloc targets a free slot, fill an allocated-but-empty
  // slot, pop a filled slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= PW'(0);
      fill_ptr_r <= PW'(0);
      rd_ptr_r   <= PW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '{pc: {XLEN{1'b0}}, instr: {XLEN{1'b0}}, filled: 1'b0};
      end
    end else if (flush) begin
      wr_ptr_r   <= PW'(0);
      fill_ptr_r <= PW'(0);
      rd_ptr_r   <= PW'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i].filled <= 1'b0;
      end
    end else begin
      if (alloc_en) begin
        mem_r[wr_ptr_r].pc     <= alloc_pc;
        mem_r[wr_ptr_r].filled <= 1'b0;
        wr_ptr_r               <= wr_ptr_r + PW'(1);
      end
      if (fill_en) begin
        mem_r[fill_ptr_r].instr  <= fill_data;
        mem_r[fill_ptr_r].filled <= 1'b1;
        fill_ptr_r               <= fill_ptr_r + PW'(1);
      end
      if (pop_en) begin
        mem_r[rd_ptr_r].filled <= 1'b0;
        rd_ptr_r               <= rd_ptr_r + PW'(1);
      end
    end
  end

  assign head_valid = mem_r[rd_ptr_r].filled;
  assign head_pc    = mem_r[rd_ptr_r].pc;
  assign head_instr = mem_r[rd_ptr_r].instr;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the fetch PC, issues in-order word reads to instruction
// memory, buffers returned words with their PC and presents {pc, instr} to decode.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   redirect_valid / redirect_pc     flush and restart fetch (pc[1:0] ignored)
//   imem_req_valid/ready/addr        read request channel (addr = fetch PC)
//   imem_rsp_valid/data              in-order read data, never back-pressured
//   dec_valid/ready/pc/instr         decode hand-off (instr = NOP when invalid)
//   stall_cnt                        only with FETCH_STALL_CNT_EN: saturating count
//                                    of cycles decode was ready but starved
// Build option: define FETCH_STALL_CNT_EN to add the stall counter and its port.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             dec_valid,
  input  logic             dec_ready,
  output logic [WIDTH-1:0] dec_pc,
  output logic [WIDTH-1:0] dec_instr
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [WIDTH-1:0] stall_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [CW-1:0]    alloc_r, alloc_nxt_s;        // slots waiting or filled
  logic [CW-1:0]    inflight_r, inflight_nxt_s;  // live requests awaiting data
  logic [CW-1:0]    drop_r, drop_nxt_s;          // stale responses still to discard

  logic             accept_s, rsp_live_s, rsp_drop_s, pop_s;
  logic             head_valid_s;
  logic [XLEN-1:0]  head_pc_s, head_instr_s;

  // Request gated by rst_n so nothing is offered while reset is held.
  assign imem_req_valid = rst_n & (alloc_r < CW'(DEPTH)) & !redirect_valid
                        & (drop_r == CW'(0));
  assign imem_req_addr  = fetch_pc_r;

  assign accept_s   = imem_req_valid & imem_req_ready;
  assign rsp_live_s = imem_rsp_valid & (drop_r == CW'(0)) & !redirect_valid;
  assign rsp_drop_s = imem_rsp_valid & (drop_r != CW'(0));
  assign pop_s      = head_valid_s & dec_ready & !redirect_valid;

  // Next-state for fetch PC and occupancy counters; redirect overrides all.
  always_comb begin
    fetch_pc_nxt_s = fetch_pc_r;
    alloc_nxt_s    = alloc_r;
    inflight_nxt_s = inflight_r;
    drop_nxt_s     = drop_r;
    if (redirect_valid) begin
      fetch_pc_nxt_s = {redirect_pc[WIDTH-1:2], 2'b00};
      alloc_nxt_s    = CW'(0);
      inflight_nxt_s = CW'(0);
      // A response landing in this cycle is discarded now, so it is not
      // waited for again. inflight_r is 0 whenever drop_r is non-zero.
      drop_nxt_s     = drop_r + inflight_r - CW'(imem_rsp_valid);
    end else begin
      if (accept_s) begin
        fetch_pc_nxt_s = fetch_pc_r + WIDTH'(INSTR_BYTES);
      end else begin
        fetch_pc_nxt_s = fetch_pc_r;
      end
      alloc_nxt_s    = alloc_r + CW'(accept_s) - CW'(pop_s);
      inflight_nxt_s = inflight_r + CW'(accept_s) - CW'(rsp_live_s);
      drop_nxt_s     = drop_r - CW'(rsp_drop_s);
    end
  end

  // Fetch PC and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      alloc_r    <= CW'(0);
      inflight_r <= CW'(0);
      drop_r     <= CW'(0);
    end else begin
      fetch_pc_r <= fetch_pc_nxt_s;
      alloc_r    <= alloc_nxt_s;
      inflight_r <= inflight_nxt_s;
      drop_r     <= drop_nxt_s;
    end
  end

  fetch_buf #(
    .DEPTH (DEPTH)
  ) u_fetch_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .alloc_en   (accept_s),
    .alloc_pc   (XLEN'(fetch_pc_r)),
    .fill_en    (rsp_live_s),
    .fill_data  (XLEN'(imem_rsp_data)),
    .pop_en     (pop_s),
    .head_valid (head_valid_s),
    .head_pc    (head_pc_s),
    .head_instr (head_instr_s)
  );

  assign dec_valid = head_valid_s;
  assign dec_pc    = head_valid_s ? WIDTH'(head_pc_s) : WIDTH'(0);
  assign dec_instr = head_valid_s ? WIDTH'(head_instr_s) : WIDTH'(NOP_INSTR);

`ifdef FETCH_STALL_CNT_EN
  logic [WIDTH-1:0] stall_cnt_r;

  // Saturating count of cycles decode was ready but had nothing to take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= WIDTH'(0);
    end else if (dec_ready & !head_valid_s & !redirect_valid
                 & (stall_cnt_r != {WIDTH{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + WIDTH'(1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  // No stall counter in this build.
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed tests for instr_fetch_unit with a small in-order
// memory model of configurable latency. Returned word = address ^ 32'hCAFE_0000.
module tb_instr_fetch_unit;

  localparam logic [31:0] K   = 32'hCAFE_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_pc         (dec_pc),
    .dec_instr      (dec_instr)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: queue of accepted requests with the cycle they become due.
  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } req_t;
  req_t        mq[$];
  logic [31:0] log_q[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      cyc++;
      #1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else begin
      if (imem_rsp_valid) mq.delete(0);
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{due: cyc + mem_lat, addr: imem_req_addr});
        log_q.push_back(imem_req_addr);
      end
      cyc++;
      #1;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mq[0].addr ^ K;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
    end
  end

  task automatic do_reset(input logic dr);
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    dec_ready = dr;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    dec_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid got %b exp 0", dec_valid); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL reset_dec_pc got %h exp 0", dec_pc); end
    checks++; if (dec_instr !== NOP) begin errors++; $display("FAIL reset_dec_instr got %h exp %h", dec_instr, NOP); end
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL release_req_valid got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL release_req_addr got %h exp 0", imem_req_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    do_reset(1'b1);
    mem_lat = 1;
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !dec_valid; i++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      e = 32'(4 * k);
      checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %b exp 1", k, dec_valid); end
      checks++; if (dec_pc !== e) begin errors++; $display("FAIL b2b_pc[%0d] got %h exp %h", k, dec_pc, e); end
      checks++; if (dec_instr !== (e ^ K)) begin errors++; $display("FAIL b2b_instr[%0d] got %h exp %h", k, dec_instr, e ^ K); end
      @(negedge clk);
    end
    checks++;
    if (log_q.size() < 4) begin
      errors++; $display("FAIL b2b_req_count got %0d exp >=4", log_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (log_q[k] !== 32'(4 * k)) begin errors++; $display("FAIL b2b_addr[%0d] got %h exp %h", k, log_q[k], 32'(4 * k)); end
      end
    end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_full();
    do_reset(1'b0);
    mem_lat = 1;
    imem_req_ready = 1'b1;
    repeat (8) @(negedge clk);
    checks++; if (log_q.size() != 4) begin errors++; $display("FAIL full_accepts got %0d exp 4", log_q.size()); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL full_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL full_head_pc got %h exp 0", dec_pc); end
    dec_ready = 1'b1;
    @(posedge clk);
    #1;
    dec_ready = 1'b0;
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL pop_req_valid got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h10) begin errors++; $display("FAIL pop_req_addr got %h exp 10", imem_req_addr); end
    @(negedge clk);
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL refull_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (log_q.size() != 5) begin errors++; $display("FAIL refull_accepts got %0d exp 5", log_q.size()); end
    checks++; if (dec_pc !== 32'h4) begin errors++; $display("FAIL refull_head_pc got %h exp 4", dec_pc); end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_redirect_inflight();
    do_reset(1'b1);
    mem_lat = 3;
    imem_req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    log_q.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL drain_req_valid got %b exp 0", imem_req_valid); end
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !dec_valid; i++) @(negedge clk);
    checks++; if (dec_pc !== 32'h100) begin errors++; $display("FAIL redir_pc got %h exp 100", dec_pc); end
    checks++; if (dec_instr !== (32'h100 ^ K)) begin errors++; $display("FAIL redir_instr got %h exp %h", dec_instr, 32'h100 ^ K); end
    checks++;
    if (log_q.size() == 0) begin
      errors++; $display("FAIL redir_first_addr got none exp 100");
    end else if (log_q[0] !== 32'h100) begin
      errors++; $display("FAIL redir_first_addr got %h exp 100", log_q[0]);
    end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_redirect_same_cycle();
    do_reset(1'b1);
    mem_lat = 1;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL same_req_valid got %b exp 1", imem_req_valid); end
    checks++; if (imem_req_addr !== 32'h100) begin errors++; $display("FAIL same_req_addr got %h exp 100", imem_req_addr); end
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL same_dec_valid got %b exp 0", dec_valid); end
    log_q.delete();
    imem_req_ready = 1'b1;
    for (int i = 0; i < 20 && !dec_valid; i++) @(negedge clk);
    checks++; if (dec_pc !== 32'h100) begin errors++; $display("FAIL same_pc got %h exp 100", dec_pc); end
    checks++; if (dec_instr !== (32'h100 ^ K)) begin errors++; $display("FAIL same_instr got %h exp %h", dec_instr, 32'h100 ^ K); end
    imem_req_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b0);
    mem_lat = 1;
    imem_req_ready = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", dec_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL mid_dec_valid got %b exp 0", dec_valid); end
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_valid got %b exp 0", imem_req_valid); end
    checks++; if (dec_instr !== NOP) begin errors++; $display("FAIL mid_dec_instr got %h exp %h", dec_instr, NOP); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    log_q.delete();
    dec_ready = 1'b1;
    #1;
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL mid_restart_addr got %h exp 0", imem_req_addr); end
    for (int i = 0; i < 20 && !dec_valid; i++) @(negedge clk);
    checks++; if (dec_pc !== 32'h0) begin errors++; $display("FAIL mid_first_pc got %h exp 0", dec_pc); end
    checks++; if (dec_instr !== K) begin errors++; $display("FAIL mid_first_instr got %h exp %h", dec_instr, K); end
    imem_req_ready = 1'b0;
  endtask

`ifdef FETCH_STALL_CNT_EN
  task automatic test_stall_cnt();
    mem_lat = 3;
    do_reset(1'b1);
    imem_req_ready = 1'b1;
    #1;
    checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL stall_reset got %0d exp 0", stall_cnt); end
    for (int i = 0; i < 20 && !dec_valid; i++) @(negedge clk);
    checks++; if (stall_cnt !== 32'd4) begin errors++; $display("FAIL stall_first_valid got %0d exp 4", stall_cnt); end
    imem_req_ready = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_redirect_inflight();
    test_redirect_same_cycle();
    test_reset_mid();
`ifdef FETCH_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
